// File: rtl/sg_array.sv
// Spike-generator array: programmable period/ticks generators swept once per time unit, emitting tagged spikes.
// Optional feature: define SG_ARRAY_OVERRUN_CNT_EN to count time_unit pulses dropped during a sweep.
module sg_array #(
  parameter int NUM_GENS = 16,
  parameter int PERIOD_W = 16,
  parameter int TAG_W    = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          prog_data,
  input  logic                 prog_valid,
  output logic                 prog_ready,
  input  logic [7:0]           gens_used,
  input  logic [NUM_GENS-1:0]  gens_en,
  input  logic                 time_unit,
  output logic [TAG_W+8:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          overrun_cnt
);

  localparam int IDX_W = (NUM_GENS > 1) ? $clog2(NUM_GENS) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, STALL} state_t;

  state_t state, state_next;

  logic [PERIOD_W-1:0] period_r [NUM_GENS];
  logic [PERIOD_W-1:0] ticks_r  [NUM_GENS];
  logic [TAG_W-1:0]    tag_r    [NUM_GENS];
  logic                sign_r   [NUM_GENS];

  logic [8:0]          idx;
  logic [IDX_W-1:0]    g;
  logic [8:0]          limit;
  logic                blocked, done, visit, start, gen_active;

  logic [1:0]          piece;
  logic [47:0]         shreg;
  logic [63:0]         word;
  logic                prog_fire, idx_ok;
  logic                wr_pend;
  logic [IDX_W-1:0]    wr_idx;
  logic [PERIOD_W-1:0] wr_period, wr_ticks;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_sign;
  logic                unused_word;

  assign prog_ready = (state == IDLE) && !reset;
  assign prog_fire  = prog_valid && prog_ready;
  assign word       = {prog_data, shreg};
  assign idx_ok     = {1'b0, word[50:43]} < 9'(NUM_GENS);
  assign unused_word = ^word;

  assign limit      = ({1'b0, gens_used} > 9'(NUM_GENS)) ? 9'(NUM_GENS) : {1'b0, gens_used};
  assign g          = idx[IDX_W-1:0];
  assign blocked    = out_valid && !out_ready;
  assign done       = idx >= limit;
  assign gen_active = gens_en[g] && (period_r[g] != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A pulse on the cycle a sweep completes restarts directly instead of being treated as an overrun.
  always_comb begin
    state_next = state;
    visit      = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (time_unit && gens_used != 8'd0) begin
          state_next = SWEEP;
          start      = 1'b1;
        end
      end
      SWEEP: begin
        if (blocked) begin
          state_next = STALL;
        end else if (done) begin
          if (time_unit && gens_used != 8'd0) start = 1'b1;
          else                                 state_next = IDLE;
        end else begin
          visit = 1'b1;
        end
      end
      STALL: begin
        if (out_ready) state_next = SWEEP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      idx       <= '0;
      piece     <= '0;
      shreg     <= '0;
      wr_pend   <= 1'b0;
      wr_idx    <= '0;
      wr_period <= '0;
      wr_ticks  <= '0;
      wr_tag    <= '0;
      wr_sign   <= 1'b0;
      for (int unsigned i = 0; i < NUM_GENS; i++) begin
        period_r[i] <= '0;
        ticks_r[i]  <= '0;
        tag_r[i]    <= '0;
        sign_r[i]   <= 1'b0;
      end
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (start)      idx <= '0;
      else if (visit) idx <= idx + 9'd1;

      if (visit && gen_active) begin
        if (ticks_r[g] == '0) begin
          ticks_r[g] <= period_r[g] - PERIOD_W'(1);
          out_data   <= {sign_r[g], idx[7:0], tag_r[g]};
          out_valid  <= 1'b1;
        end else begin
          ticks_r[g] <= ticks_r[g] - PERIOD_W'(1);
        end
      end

      wr_pend <= 1'b0;
      if (prog_fire) begin
        piece <= piece + 2'd1;
        case (piece)
          2'd0: shreg[15:0]  <= prog_data;
          2'd1: shreg[31:16] <= prog_data;
          2'd2: shreg[47:32] <= prog_data;
          default: begin
            wr_pend   <= idx_ok;
            wr_idx    <= word[43 +: IDX_W];
            wr_period <= word[27 +: PERIOD_W];
            wr_ticks  <= word[11 +: PERIOD_W];
            wr_tag    <= word[0 +: TAG_W];
            wr_sign   <= word[51];
          end
        endcase
      end

      // Programming write is placed last so it wins over a same-cycle visit to that generator.
      if (wr_pend) begin
        period_r[wr_idx] <= wr_period;
        ticks_r[wr_idx]  <= wr_ticks;
        tag_r[wr_idx]    <= wr_tag;
        sign_r[wr_idx]   <= wr_sign;
      end
    end
  end

`ifdef SG_ARRAY_OVERRUN_CNT_EN
  logic        overrun_hit;
  logic [15:0] overrun_q;

  assign overrun_hit = time_unit && (state != IDLE) && (state_next != IDLE) && !start;

  always_ff @(posedge clk) begin
    if (reset)                              overrun_q <= '0;
    else if (overrun_hit && overrun_q != '1) overrun_q <= overrun_q + 16'd1;
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = '0;
`endif

endmodule
